// File: rtl/dmi_initiator.sv
// DMI transport initiator: turns DMI UpdateDR/CaptureDR strobes into one outstanding request and keeps sticky dmistat.
// Request issues the cycle after update; define DMI_INITIATOR_TIMEOUT_EN to abandon responses after TIMEOUT_CYCLES.
module dmi_initiator #(
  parameter int ADDR_W = 7,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              upd_valid,
  input  logic [1:0]        upd_op,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [31:0]       upd_data,
  input  logic              cap_valid,
  output logic [ADDR_W-1:0] cap_addr,
  output logic [31:0]       cap_data,
  output logic [1:0]        cap_op,
  input  logic              dmireset,
  input  logic              dmihardreset,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [31:0]       req_data,
  output logic [1:0]        req_op,
  input  logic              resp_valid,
  output logic              resp_ready,
  input  logic [31:0]       resp_data,
  input  logic [1:0]        resp_resp,
  output logic              busy,
  output logic [1:0]        sticky
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t     state, stateNext;
  logic [1:0] stickyNext;
  logic       accept, reqFire, respFire, busySet, failSet, timeout;

  assign req_valid  = (state == REQ);
  assign resp_ready = (state != REQ);
  assign busy       = (state != IDLE);

`ifdef DMI_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] toCnt;

  // Held at zero outside RESP so each RESP visit starts counting from 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      toCnt <= '0;
    else if (dmihardreset || state != RESP)
      toCnt <= '0;
    else
      toCnt <= toCnt + 1'b1;
  end

  assign timeout = (state == RESP) && !resp_valid && (toCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unusedTimeoutCfg;
  assign unusedTimeoutCfg = (TIMEOUT_CYCLES > 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sticky <= 2'd0;
    end else begin
      state  <= stateNext;
      sticky <= stickyNext;
    end
  end

  always_comb begin
    stateNext  = state;
    stickyNext = sticky;
    reqFire    = req_valid && req_ready;
    respFire   = (state == RESP) && resp_valid;
    accept     = upd_valid && (state == IDLE) && (sticky == 2'd0) &&
                 (upd_op == 2'd1 || upd_op == 2'd2) && !dmihardreset;
    busySet    = (upd_valid || cap_valid) && (state != IDLE);
    failSet    = (respFire && resp_resp != 2'd0) || timeout;

    // Only the first error since the last clear is recorded.
    if (sticky == 2'd0) begin
      if (busySet)
        stickyNext = 2'd3;
      else if (failSet)
        stickyNext = 2'd2;
    end
    if (dmihardreset || dmireset)
      stickyNext = 2'd0;

    case (state)
      IDLE:    if (accept) stateNext = REQ;
      REQ:     if (reqFire) stateNext = RESP;
      RESP:    if (respFire || timeout) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (dmihardreset)
      stateNext = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_addr <= '0;
      req_data <= '0;
      req_op   <= 2'd0;
      cap_addr <= '0;
      cap_data <= '0;
      cap_op   <= 2'd0;
    end else begin
      if (accept) begin
        req_addr <= upd_addr;
        req_data <= upd_data;
        req_op   <= upd_op;
        cap_addr <= upd_addr;
      end
      // An aborted transaction must not leak its response into capture data.
      if (respFire && !dmihardreset)
        cap_data <= resp_data;
      if (cap_valid) begin
        if (sticky != 2'd0)
          cap_op <= sticky;
        else if (state != IDLE)
          cap_op <= 2'd3;
        else
          cap_op <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_dmi_initiator.sv
// Bench for dmi_initiator: directed scenarios with literal expectations, then random traffic vs a transaction-level model.
module tb_dmi_initiator;
  localparam int AW = 7;
  localparam int TC = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          upd_valid = 1'b0;
  logic [1:0]    upd_op = 2'd0;
  logic [AW-1:0] upd_addr = '0;
  logic [31:0]   upd_data = '0;
  logic          cap_valid = 1'b0;
  logic [AW-1:0] cap_addr;
  logic [31:0]   cap_data;
  logic [1:0]    cap_op;
  logic          dmireset = 1'b0;
  logic          dmihardreset = 1'b0;
  logic          req_valid;
  logic          req_ready = 1'b0;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_data;
  logic [1:0]    req_op;
  logic          resp_valid = 1'b0;
  logic          resp_ready;
  logic [31:0]   resp_data = '0;
  logic [1:0]    resp_resp = 2'd0;
  logic          busy;
  logic [1:0]    sticky;

  dmi_initiator #(.ADDR_W(AW), .TIMEOUT_CYCLES(TC)) dut (
    .clock(clock), .reset(reset),
    .upd_valid(upd_valid), .upd_op(upd_op), .upd_addr(upd_addr), .upd_data(upd_data),
    .cap_valid(cap_valid), .cap_addr(cap_addr), .cap_data(cap_data), .cap_op(cap_op),
    .dmireset(dmireset), .dmihardreset(dmihardreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_resp(resp_resp), .busy(busy), .sticky(sticky)
  );

  always #5 clock = ~clock;

  int nChecks = 0;
  int nPass = 0;
  int dutFires = 0;

  always @(posedge clock)
    if (!reset && req_valid && req_ready) dutFires++;

  // Transaction-level model: a request is either waiting to be taken, in flight, or absent.
  bit            mPend, mOut;
  int            mWait;
  logic [1:0]    mSticky, mCapOp, mOp;
  logic [AW-1:0] mAddr, mCapAddr;
  logic [31:0]   mData, mCapData;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic modelReset();
    mPend = 0; mOut = 0; mWait = 0;
    mSticky = 0; mCapOp = 0; mOp = 0;
    mAddr = 0; mCapAddr = 0; mData = 0; mCapData = 0;
  endtask

  task automatic modelUpdate();
    bit idle, respDone, tmo;
    logic [1:0] nSticky;
    idle = !mPend && !mOut;
    respDone = mOut && resp_valid;
    tmo = 0;
`ifdef DMI_INITIATOR_TIMEOUT_EN
    if (mOut && !respDone && mWait == TC - 1) tmo = 1;
`endif
    nSticky = mSticky;
    if (mSticky == 0) begin
      if ((upd_valid || cap_valid) && !idle) nSticky = 3;
      else if ((respDone && resp_resp != 0) || tmo) nSticky = 2;
    end
    if (dmireset || dmihardreset) nSticky = 0;
    if (cap_valid) mCapOp = (mSticky != 0) ? mSticky : (idle ? 2'd0 : 2'd3);
    if (dmihardreset) begin
      mPend = 0; mOut = 0;
    end else if (mPend) begin
      if (req_ready) begin mPend = 0; mOut = 1; mWait = 0; end
    end else if (mOut) begin
      if (respDone) begin mCapData = resp_data; mOut = 0; end
      else if (tmo) mOut = 0;
      else mWait++;
    end else if (upd_valid && mSticky == 0 && (upd_op == 1 || upd_op == 2)) begin
      mPend = 1; mAddr = upd_addr; mData = upd_data; mOp = upd_op; mCapAddr = upd_addr;
    end
    mSticky = nSticky;
  endtask

  task automatic compareAll();
    check("req_valid", req_valid, mPend);
    check("resp_ready", resp_ready, !mPend);
    check("busy", busy, mPend || mOut);
    check("sticky", sticky, mSticky);
    check("cap_op", cap_op, mCapOp);
    check("cap_addr", cap_addr, mCapAddr);
    check("cap_data", cap_data, mCapData);
    if (mPend) begin
      check("req_addr", req_addr, mAddr);
      check("req_data", req_data, mData);
      check("req_op", req_op, mOp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    modelUpdate();
    @(negedge clock);
    compareAll();
  endtask

  task automatic clearIn();
    upd_valid = 0; cap_valid = 0; dmireset = 0; dmihardreset = 0; resp_valid = 0; resp_resp = 0;
  endtask

  task automatic update(input logic [1:0] op, input logic [AW-1:0] a, input logic [31:0] d);
    upd_valid = 1; upd_op = op; upd_addr = a; upd_data = d;
    step();
    upd_valid = 0;
  endtask

  task automatic respond(input logic [1:0] r, input logic [31:0] d);
    resp_valid = 1; resp_resp = r; resp_data = d;
    step();
    resp_valid = 0; resp_resp = 0;
  endtask

  initial begin
    int f0;
    modelReset();
    repeat (2) @(negedge clock);
    reset = 0;
    compareAll();
    check("rst req_valid", req_valid, 0);
    check("rst resp_ready", resp_ready, 1);
    check("rst busy", busy, 0);
    check("rst cap_data", cap_data, 0);

    // Read with immediate acceptance, response three cycles later.
    f0 = dutFires;
    req_ready = 1;
    update(2'd1, 7'h11, 32'h0);
    check("rd req_valid", req_valid, 1);
    check("rd req_op", req_op, 1);
    check("rd req_addr", req_addr, 7'h11);
    step();
    check("rd in flight", busy, 1);
    check("rd req_valid drop", req_valid, 0);
    repeat (2) step();
    respond(2'd0, 32'hDEADBEEF);
    cap_valid = 1; step(); cap_valid = 0;
    check("rd cap_data", cap_data, 32'hDEADBEEF);
    check("rd cap_op", cap_op, 0);
    check("rd cap_addr", cap_addr, 7'h11);
    check("rd fires", dutFires - f0, 1);

    // Write held off by req_ready for five cycles.
    f0 = dutFires;
    req_ready = 0;
    update(2'd2, 7'h10, 32'h1);
    for (int i = 0; i < 5; i++) begin
      check("bp req_valid", req_valid, 1);
      check("bp req_data", req_data, 32'h1);
      check("bp req_addr", req_addr, 7'h10);
      if (i == 4) req_ready = 1;
      step();
    end
    check("bp fires", dutFires - f0, 1);
    check("bp busy", busy, 1);
    req_ready = 0;
    step();
    respond(2'd0, 32'h0);
    check("bp done", busy, 0);

    // Update during an outstanding transaction sets busy status.
    req_ready = 1;
    update(2'd1, 7'h05, 32'h0);
    step();
    update(2'd1, 7'h22, 32'h0);
    check("busy sticky", sticky, 3);
    cap_valid = 1; step(); cap_valid = 0;
    check("busy cap_op", cap_op, 3);
    respond(2'd0, 32'hAAAA5555);
    update(2'd2, 7'h33, 32'h0);
    check("busy ignored", req_valid, 0);
    check("busy cap_addr", cap_addr, 7'h05);
    dmireset = 1; step(); dmireset = 0;
    check("dmireset sticky", sticky, 0);
    update(2'd1, 7'h44, 32'h0);
    check("post-clear req", req_valid, 1);
    check("post-clear addr", req_addr, 7'h44);
    step();

    // Failed response.
    respond(2'd2, 32'h0BAD0BAD);
    check("fail sticky", sticky, 2);
    cap_valid = 1; step(); cap_valid = 0;
    check("fail cap_op", cap_op, 2);
    cap_valid = 1; upd_valid = 1; upd_op = 2'd1; step(); cap_valid = 0; upd_valid = 0;
    check("fail kept", sticky, 2);
    check("fail no req", req_valid, 0);

    // Hard reset during REQ, then a stray response.
    dmireset = 1; step(); dmireset = 0;
    req_ready = 0;
    update(2'd1, 7'h55, 32'h0);
    check("hr pre req_valid", req_valid, 1);
    dmihardreset = 1; step(); dmihardreset = 0;
    check("hr req_valid", req_valid, 0);
    check("hr busy", busy, 0);
    check("hr sticky", sticky, 0);
    check("hr resp_ready", resp_ready, 1);
    respond(2'd0, 32'h12345678);
    check("hr stray cap_data", cap_data, 32'h0BAD0BAD);

    // Missing response.
    req_ready = 1;
    update(2'd1, 7'h66, 32'h0);
    step();
`ifdef DMI_INITIATOR_TIMEOUT_EN
    repeat (TC - 1) step();
    check("to still busy", busy, 1);
    step();
    check("to idle", busy, 0);
    check("to sticky", sticky, 2);
    dmireset = 1; step(); dmireset = 0;
`else
    repeat (20) step();
    check("no-to busy", busy, 1);
    respond(2'd0, 32'h0);
    check("no-to done", busy, 0);
`endif

    // Randomized traffic, with one asynchronous reset in the middle.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        #2 reset = 1;
        modelReset();
        #1;
        check("arst req_valid", req_valid, 0);
        check("arst busy", busy, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 0;
        compareAll();
      end
      upd_valid    = ($urandom_range(0, 99) < 20);
      upd_op       = 2'($urandom);
      upd_addr     = AW'($urandom);
      upd_data     = $urandom;
      cap_valid    = ($urandom_range(0, 99) < 15);
      dmireset     = ($urandom_range(0, 99) < 3);
      dmihardreset = ($urandom_range(0, 99) < 2);
      req_ready    = ($urandom_range(0, 99) < 50);
      resp_valid   = ($urandom_range(0, 99) < 30);
      resp_data    = $urandom;
      resp_resp    = ($urandom_range(0, 99) < 25) ? 2'($urandom_range(1, 3)) : 2'd0;
      step();
    end
    clearIn();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
